// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Keeps the BCD score and the player's lives. Invader hits are
//            queued so that simultaneous hits are all scored, one target per
//            cycle. A one-time extra life is awarded when the score crosses a
//            threshold. Player deaths, respawn delay and game over are
//            sequenced by a small state machine. Sits between the collision
//            detectors and the HUD renderer.
// Ports    : clk               - system clock
//            rst_n             - synchronous active-low reset
//            invader_collision - per-target hit pulses, any number per cycle
//            player_collision  - player hit pulse
//            new_game          - restart request, honoured only in GAME_OVER
//            score             - BCD score, 4*SCORE_DIGITS bits
//            lives             - remaining lives
//            player_alive      - high while PLAYING
//            game_over         - high while in GAME_OVER
//            score_busy        - hit queue holds unserved hits
//            extra_life        - one-cycle pulse when the extra life is awarded
//            hiscore           - best final score (SCORE_KEEPER_HISCORE_EN only)
// Options  : define SCORE_KEEPER_HISCORE_EN to add the hiscore output/register.
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int                        NUM_TARGETS    = 6,
    parameter int                        SCORE_DIGITS   = 3,
    parameter logic [8*NUM_TARGETS-1:0]  TARGET_POINTS  = {8'h30, 8'h20, 8'h20, 8'h10, 8'h10, 8'h10},
    parameter int                        LIVES_W        = 2,
    parameter int                        START_LIVES    = 3,
    parameter int                        MAX_LIVES      = 3,
    parameter logic [4*SCORE_DIGITS-1:0] EXTRA_LIFE_AT  = 12'h050,
    parameter logic [15:0]               RESPAWN_CYCLES = 16'd120
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_TARGETS-1:0]    invader_collision,
    input  logic                      player_collision,
    input  logic                      new_game,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [LIVES_W-1:0]        lives,
    output logic                      player_alive,
    output logic                      game_over,
    output logic                      score_busy,
    output logic                      extra_life
`ifdef SCORE_KEEPER_HISCORE_EN
    ,
    output logic [4*SCORE_DIGITS-1:0] hiscore
`endif
);

    localparam int                  c_SW           = 4 * SCORE_DIGITS;
    localparam logic [1:0]          c_ST_PLAYING   = 2'd0;
    localparam logic [1:0]          c_ST_DYING     = 2'd1;
    localparam logic [1:0]          c_ST_GAME_OVER = 2'd2;
    localparam logic [LIVES_W-1:0]  c_START_LIVES  = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0]  c_MAX_LIVES    = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0]  c_ONE_LIFE     = LIVES_W'(1);
    localparam logic [LIVES_W-1:0]  c_NO_LIVES     = '0;
    localparam logic [15:0]         c_RESPAWN_LAST = RESPAWN_CYCLES - 16'd1;
    localparam logic [c_SW-1:0]     c_ALL_NINES    = {SCORE_DIGITS{4'h9}};

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [c_SW-1:0]        r_score;
    logic [LIVES_W-1:0]     r_lives;
    logic [NUM_TARGETS-1:0] r_pending;
    logic [15:0]            r_cnt;
    logic                   r_extra_awarded;
    logic                   r_extra_life;
    logic                   r_player_alive;
    logic                   r_game_over;
    logic                   r_busy;

    // ------------------------------------------------------------------------
    // Combinational next-value logic
    // ------------------------------------------------------------------------
    logic [NUM_TARGETS-1:0] w_gated;
    logic [NUM_TARGETS-1:0] w_served;
    logic [NUM_TARGETS-1:0] w_pending_next;
    logic [7:0]             w_points;
    logic [c_SW+7:0]        w_addend;
    logic [c_SW-1:0]        w_sum;
    logic [4:0]             w_digit_sum;
    logic [4:0]             w_digit_adj;
    logic                   w_carry;
    logic                   w_saturate;
    logic [c_SW-1:0]        w_score_next;
    logic                   w_award;
    logic                   w_death;
    logic [LIVES_W-1:0]     w_lives_after_death;
    logic [LIVES_W-1:0]     w_lives_next;

    always_comb begin
        w_gated             = '0;
        w_served            = '0;
        w_pending_next      = '0;
        w_points            = '0;
        w_addend            = '0;
        w_sum               = '0;
        w_digit_sum         = '0;
        w_digit_adj         = '0;
        w_carry             = 1'b0;
        w_saturate          = 1'b0;
        w_score_next        = r_score;
        w_award             = 1'b0;
        w_death             = 1'b0;
        w_lives_after_death = r_lives;
        w_lives_next        = r_lives;

        // Hits arriving in GAME_OVER are dropped; queued ones still drain.
        w_gated = (r_state != c_ST_GAME_OVER) ? invader_collision : '0;

        // Isolate the lowest pending bit (two's complement trick). A new hit
        // on a still-pending index simply ORs into the same bit.
        w_served       = r_pending & (-r_pending);
        w_pending_next = (r_pending & ~w_served) | w_gated;

        // w_served is one-hot (or zero), so an OR-mux picks its point value.
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (w_served[i]) begin
                w_points = w_points | TARGET_POINTS[8*i +: 8];
            end
        end

        // Digit-serial BCD ripple add. The addend is widened so that a
        // narrow score still sees the upper point digit (forcing saturation).
        w_addend = {{c_SW{1'b0}}, w_points};
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            w_digit_sum = {1'b0, r_score[4*d +: 4]} + {1'b0, w_addend[4*d +: 4]} + {4'b0000, w_carry};
            w_digit_adj = w_digit_sum - 5'd10;
            if (w_digit_sum > 5'd9) begin
                w_sum[4*d +: 4] = w_digit_adj[3:0];
                w_carry         = 1'b1;
            end else begin
                w_sum[4*d +: 4] = w_digit_sum[3:0];
                w_carry         = 1'b0;
            end
        end
        w_saturate = w_carry | (|w_addend[c_SW +: 8]);

        if (r_pending != '0) begin
            w_score_next = w_saturate ? c_ALL_NINES : w_sum;
        end

        w_award = (EXTRA_LIFE_AT != '0) && !r_extra_awarded && (w_score_next >= EXTRA_LIFE_AT);

        // Death is applied before the award, so a simultaneous death and
        // award always nets to an unchanged life count.
        w_death = (r_state == c_ST_PLAYING) && player_collision;
        if (w_death) begin
            w_lives_after_death = r_lives - c_ONE_LIFE;
        end
        w_lives_next = w_lives_after_death;
        if (w_award && (w_lives_after_death < c_MAX_LIVES)) begin
            w_lives_next = w_lives_after_death + c_ONE_LIFE;
        end
    end

    // ------------------------------------------------------------------------
    // Main sequential block: queue, score, lives and game FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= c_ST_PLAYING;
            r_score         <= '0;
            r_lives         <= c_START_LIVES;
            r_pending       <= '0;
            r_cnt           <= '0;
            r_extra_awarded <= 1'b0;
            r_extra_life    <= 1'b0;
            r_player_alive  <= 1'b1;
            r_game_over     <= 1'b0;
            r_busy          <= 1'b0;
        end else if ((r_state == c_ST_GAME_OVER) && new_game) begin
            // Fresh game: any queued or same-cycle hits are discarded.
            r_state         <= c_ST_PLAYING;
            r_score         <= '0;
            r_lives         <= c_START_LIVES;
            r_pending       <= '0;
            r_cnt           <= '0;
            r_extra_awarded <= 1'b0;
            r_extra_life    <= 1'b0;
            r_player_alive  <= 1'b1;
            r_game_over     <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_busy       <= |w_pending_next;
            r_score      <= w_score_next;
            r_lives      <= w_lives_next;
            r_extra_life <= w_award;
            if (w_award) begin
                r_extra_awarded <= 1'b1;
            end

            case (r_state)
                c_ST_PLAYING: begin
                    if (w_death) begin
                        r_player_alive <= 1'b0;
                        if (w_lives_next == c_NO_LIVES) begin
                            r_state     <= c_ST_GAME_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= c_ST_DYING;
                            r_cnt   <= c_RESPAWN_LAST;
                        end
                    end
                end
                c_ST_DYING: begin
                    if (r_cnt == 16'd0) begin
                        r_state        <= c_ST_PLAYING;
                        r_player_alive <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                c_ST_GAME_OVER: begin
                    // Held here until new_game; queue keeps draining above.
                end
                default: begin
                    r_state        <= c_ST_PLAYING;
                    r_player_alive <= 1'b1;
                    r_game_over    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCORE_KEEPER_HISCORE_EN
    // ------------------------------------------------------------------------
    // High score: captured once the final score has settled in GAME_OVER.
    // Survives new_game; only reset clears it. Valid BCD orders like binary.
    // ------------------------------------------------------------------------
    logic [c_SW-1:0] r_hiscore;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hiscore <= '0;
        end else if ((r_state == c_ST_GAME_OVER) && (r_pending == '0) && (r_score > r_hiscore)) begin
            r_hiscore <= r_score;
        end
    end

    assign hiscore = r_hiscore;
`endif

    assign score        = r_score;
    assign lives        = r_lives;
    assign player_alive = r_player_alive;
    assign game_over    = r_game_over;
    assign score_busy   = r_busy;
    assign extra_life   = r_extra_life;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Purpose  : Self-checking bench for score_keeper: a vector table, directed
//            multi-cycle sequences and randomized traffic, all compared
//            against an integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    localparam int c_ST_PLAY  = 0;
    localparam int c_ST_DYING = 1;
    localparam int c_ST_GO    = 2;
    localparam int c_RESPAWN  = 120;
    localparam int c_MAXSCORE = 999;
    localparam int c_XL_AT    = 50;
    localparam int c_START    = 3;
    localparam int c_MAXLIVES = 3;

    logic        clk;
    logic        rst_n;
    logic [5:0]  invader_collision;
    logic        player_collision;
    logic        new_game;
    logic [11:0] score;
    logic [1:0]  lives;
    logic        player_alive;
    logic        game_over;
    logic        score_busy;
    logic        extra_life;
`ifdef SCORE_KEEPER_HISCORE_EN
    logic [11:0] hiscore;
`endif

    score_keeper dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .invader_collision (invader_collision),
        .player_collision  (player_collision),
        .new_game          (new_game),
        .score             (score),
        .lives             (lives),
        .player_alive      (player_alive),
        .game_over         (game_over),
        .score_busy        (score_busy),
        .extra_life        (extra_life)
`ifdef SCORE_KEEPER_HISCORE_EN
        ,
        .hiscore           (hiscore)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int xl_seen  = 0;

    // Reference model state (plain integers)
    int       m_score;
    int       m_lives;
    int       m_state;
    int       m_left;
    int       m_hi;
    bit       m_awarded;
    bit       m_xl;
    bit [5:0] m_pend;

    function automatic int pts(input int i);
        case (i)
            0, 1, 2: return 10;
            3, 4:    return 20;
            default: return 30;
        endcase
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [5:0] inv, input logic pc, input logic ng);
        bit award;
        bit dead;
        if (!r) begin
            m_score = 0; m_lives = c_START; m_pend = '0; m_state = c_ST_PLAY;
            m_left = 0; m_awarded = 0; m_xl = 0; m_hi = 0;
            return;
        end
        if (m_state == c_ST_GO && m_pend == 0 && m_score > m_hi) m_hi = m_score;
        if (m_state == c_ST_GO && ng) begin
            m_score = 0; m_lives = c_START; m_pend = '0; m_awarded = 0;
            m_xl = 0; m_state = c_ST_PLAY; m_left = 0;
            return;
        end
        if (m_pend != 0) begin
            for (int i = 0; i < 6; i++) begin
                if (m_pend[i]) begin
                    m_score += pts(i);
                    m_pend[i] = 1'b0;
                    break;
                end
            end
            if (m_score > c_MAXSCORE) m_score = c_MAXSCORE;
        end
        if (m_state != c_ST_GO) m_pend = m_pend | inv;
        award = !m_awarded && (m_score >= c_XL_AT);
        m_xl = award;
        if (award) m_awarded = 1;
        dead = (m_state == c_ST_PLAY) && pc;
        if (dead) m_lives--;
        if (award && m_lives < c_MAXLIVES) m_lives++;
        if (dead) begin
            if (m_lives == 0) m_state = c_ST_GO;
            else begin
                m_state = c_ST_DYING;
                m_left  = c_RESPAWN;
            end
        end else if (m_state == c_ST_DYING) begin
            m_left--;
            if (m_left == 0) m_state = c_ST_PLAY;
        end
    endtask

    task automatic compare_model();
        chk("model_score", 32'(score), 32'(to_bcd(m_score)));
        chk("model_lives", 32'(lives), m_lives);
        chk("model_alive", 32'(player_alive), 32'(m_state == c_ST_PLAY));
        chk("model_game_over", 32'(game_over), 32'(m_state == c_ST_GO));
        chk("model_busy", 32'(score_busy), 32'(m_pend != 0));
        chk("model_extra_life", 32'(extra_life), 32'(m_xl));
`ifdef SCORE_KEEPER_HISCORE_EN
        chk("model_hiscore", 32'(hiscore), 32'(to_bcd(m_hi)));
`endif
    endtask

    // One clock: drive on negedge, update model at posedge, sample 1ns later.
    task automatic step(input logic r, input logic [5:0] inv, input logic pc, input logic ng);
        @(negedge clk);
        rst_n = r; invader_collision = inv; player_collision = pc; new_game = ng;
        @(posedge clk);
        model_update(r, inv, pc, ng);
        #1;
        compare_model();
        if (extra_life) xl_seen++;
    endtask

    task automatic idle();
        step(1'b1, 6'h00, 1'b0, 1'b0);
    endtask

    task automatic burst(input logic [5:0] pat);
        int n;
        step(1'b1, pat, 1'b0, 1'b0);
        n = 0;
        while (score_busy && n < 20) begin
            idle();
            n++;
        end
        chk("drain_bound", 32'(score_busy), 32'd0);
    endtask

    task automatic wait_alive();
        int n;
        n = 0;
        while (!player_alive && n < 300) begin
            idle();
            n++;
        end
        chk("respawn_bound", 32'(player_alive), 32'd1);
    endtask

    typedef struct {
        logic       r;
        logic [5:0] inv;
        logic       pc;
        logic       ng;
        logic [11:0] sc;
        logic [1:0] lv;
        logic       al;
        logic       go;
        logic       bz;
        logic       xl;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int low;
        rst_n = 1'b0; invader_collision = '0; player_collision = 1'b0; new_game = 1'b0;
        m_score = 0; m_lives = c_START; m_pend = '0; m_state = c_ST_PLAY;
        m_left = 0; m_awarded = 0; m_xl = 0; m_hi = 0;

        //            rst  inv    pc  ng  score    lv  al  go  bz  xl
        tbl[0]  = '{1'b0, 6'h00, 1'b0, 1'b0, 12'h000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 6'h01, 1'b0, 1'b0, 12'h000, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h010, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 6'h00, 1'b0, 1'b0, 12'h000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 6'h23, 1'b0, 1'b0, 12'h000, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h010, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h020, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h050, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h050, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 6'h03, 1'b0, 1'b0, 12'h050, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 6'h02, 1'b0, 1'b0, 12'h060, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h070, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h070, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 6'h00, 1'b1, 1'b0, 12'h070, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 6'h00, 1'b1, 1'b0, 12'h070, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 6'h20, 1'b0, 1'b0, 12'h070, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 6'h00, 1'b0, 1'b0, 12'h100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].inv, tbl[i].pc, tbl[i].ng);
            chk("tbl_score", 32'(score), 32'(tbl[i].sc));
            chk("tbl_lives", 32'(lives), 32'(tbl[i].lv));
            chk("tbl_alive", 32'(player_alive), 32'(tbl[i].al));
            chk("tbl_game_over", 32'(game_over), 32'(tbl[i].go));
            chk("tbl_busy", 32'(score_busy), 32'(tbl[i].bz));
            chk("tbl_extra_life", 32'(extra_life), 32'(tbl[i].xl));
        end

        // Respawn length, with a second hit ignored while dying.
        step(1'b0, 6'h00, 1'b0, 1'b0);
        step(1'b1, 6'h00, 1'b1, 1'b0);
        low = player_alive ? 0 : 1;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 6'h00, (i == 5) ? 1'b1 : 1'b0, 1'b0);
            if (player_alive) break;
            low++;
        end
        chk("respawn_low_cycles", low, c_RESPAWN);
        chk("dying_hit_ignored_lives", 32'(lives), 32'd2);

        // Saturation at 999.
        step(1'b0, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) burst(6'h3F);
        burst(6'h3E);
        chk("sat_pre_990", 32'(score), 32'h990);
        burst(6'h20);
        chk("sat_999", 32'(score), 32'h999);
        burst(6'h20);
        chk("sat_hold_999", 32'(score), 32'h999);

        // Extra life from lives=2, and no second award.
        step(1'b0, 6'h00, 1'b0, 1'b0);
        step(1'b1, 6'h00, 1'b1, 1'b0);
        wait_alive();
        burst(6'h08);
        step(1'b1, 6'h20, 1'b0, 1'b0);
        idle();
        chk("xl_pulse", 32'(extra_life), 32'd1);
        chk("xl_lives", 32'(lives), 32'd3);
        chk("xl_score", 32'(score), 32'h050);
        xl_seen = 0;
        step(1'b1, 6'h00, 1'b1, 1'b0);
        wait_alive();
        burst(6'h3F);
        chk("xl_no_second", xl_seen, 0);
        chk("xl_after_lives", 32'(lives), 32'd2);
        chk("xl_after_score", 32'(score), 32'h150);

        // Death and award in the same cycle from lives=1, then game over.
        step(1'b0, 6'h00, 1'b0, 1'b0);
        step(1'b1, 6'h00, 1'b1, 1'b0);
        wait_alive();
        step(1'b1, 6'h00, 1'b1, 1'b0);
        wait_alive();
        chk("pre_combo_lives", 32'(lives), 32'd1);
        burst(6'h08);
        step(1'b1, 6'h20, 1'b0, 1'b0);
        step(1'b1, 6'h00, 1'b1, 1'b0);
        chk("combo_lives", 32'(lives), 32'd1);
        chk("combo_game_over", 32'(game_over), 32'd0);
        chk("combo_alive", 32'(player_alive), 32'd0);
        chk("combo_xl", 32'(extra_life), 32'd1);
        wait_alive();
        step(1'b1, 6'h00, 1'b1, 1'b0);
        chk("go_flag", 32'(game_over), 32'd1);
        chk("go_lives", 32'(lives), 32'd0);
        step(1'b1, 6'h3F, 1'b0, 1'b0);
        chk("go_hit_ignored_busy", 32'(score_busy), 32'd0);
        idle();
        chk("go_score_frozen", 32'(score), 32'h050);
`ifdef SCORE_KEEPER_HISCORE_EN
        chk("hiscore_capture", 32'(hiscore), 32'h050);
`endif
        step(1'b1, 6'h3F, 1'b0, 1'b1);
        chk("ng_score", 32'(score), 32'h000);
        chk("ng_lives", 32'(lives), 32'd3);
        chk("ng_alive", 32'(player_alive), 32'd1);
        chk("ng_game_over", 32'(game_over), 32'd0);
        chk("ng_drop_busy", 32'(score_busy), 32'd0);
        idle();
        chk("ng_drop_score", 32'(score), 32'h000);
`ifdef SCORE_KEEPER_HISCORE_EN
        chk("hiscore_kept", 32'(hiscore), 32'h050);
`endif

        // Randomized traffic against the model.
        step(1'b0, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [5:0] inv;
            logic       pc;
            logic       ng;
            r   = ($urandom_range(0, 499) != 0);
            inv = ($urandom_range(0, 3) == 0) ? 6'($urandom & $urandom & $urandom) : 6'h00;
            pc  = ($urandom_range(0, 39) == 0);
            ng  = ($urandom_range(0, 19) == 0);
            step(r, inv, pc, ng);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Parametrised successor to the single-counter score/lives logic.
- Accumulates a multi-digit BCD score from per-target point values and queues simultaneous hits so none are lost.
- Manages lives with a respawn delay, a one-time extra-life award, and a game-over/new-game state machine.
- Sits between the collision detectors and the HUD/text renderer.

Parameters:
- NUM_TARGETS, 6: width of invader_collision; one bit per target class/row.
- SCORE_DIGITS, 3: BCD digits in score (score width 4*SCORE_DIGITS).
- TARGET_POINTS, {8'h30,8'h20,8'h20,8'h10,8'h10,8'h10}: packed 2-digit BCD points, entry i = bits [8i+7:8i].
- LIVES_W, 2: width of lives.
- START_LIVES, 3: lives after reset/new game.
- MAX_LIVES, 3: extra life never raises lives above this.
- EXTRA_LIFE_AT, 12'h050: BCD threshold for the one-time extra life; 0 disables the award.
- RESPAWN_CYCLES, 16'd120: cycles spent in DYING.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- invader_collision  in  NUM_TARGETS  per-target hit pulses, any number per cycle
- player_collision  in  1  player hit pulse
- new_game  in  1  restart request, honoured only in GAME_OVER
- score  out  4*SCORE_DIGITS  BCD score
- lives  out  LIVES_W  remaining lives
- player_alive  out  1  high in PLAYING
- game_over  out  1  high in GAME_OVER
- score_busy  out  1  pending hit queue non-empty
- extra_life  out  1  one-cycle pulse when the extra life is awarded

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at posedge):
  - score=0, lives=START_LIVES, pending=0, state=PLAYING.
  - extra_life=0, extra_awarded=0, respawn counter=0.
  - All outputs are registered.
- Hit queue:
  - pending_next = (pending & ~served) | (invader_collision gated by state!=GAME_OVER).
  - served = lowest set bit of pending.
  - A repeat hit on an index already pending merges and is counted once.
- Scoring:
  - Each cycle with pending!=0, score <= score + TARGET_POINTS[served], BCD ripple add.
  - Score saturates at all-9s and never wraps.
  - Latency: hit at cycle t is latched at t+1; k simultaneous hits are fully scored by end of cycle t+k+1.
- Extra life:
  - Awarded on the first cycle the updated score >= EXTRA_LIFE_AT (nonzero), once per game.
  - Sets extra_awarded and pulses extra_life.
  - lives increments only if lives<MAX_LIVES; the flag is set either way.
- FSM PLAYING:
  - player_collision decrements lives.
  - If the resulting lives==0 -> GAME_OVER, else -> DYING with counter=RESPAWN_CYCLES-1.
- FSM DYING:
  - player_collision ignored; pending hits still scored (bullets in flight).
  - Counter decrements each cycle; at 0 -> PLAYING.
- FSM GAME_OVER:
  - All collisions ignored; pending queue drains and scores normally.
  - new_game -> PLAYING: score=0, lives=START_LIVES, pending=0, extra_awarded=0.
- Simultaneous events:
  - Death and extra-life award in the same cycle net to lives unchanged; from lives=1 this means no game over and the FSM enters DYING.
  - new_game with invader_collision in the same cycle: the collision is dropped.
- lives==0 is reachable only in GAME_OVER.
- rst_n low mid-DYING or mid-drain: immediate return to reset values.

Optional Feature:
- SCORE_KEEPER_HISCORE_EN defined:
  - Adds output hiscore (4*SCORE_DIGITS, BCD).
  - Cleared by rst_n, not by new_game.
  - Updated to score on the cycle the FSM is in GAME_OVER with pending==0 and score>hiscore.
- Undefined: no hiscore port or register.

Test Plan:
- Reset, then invader_collision=6'b000001 one cycle -> score=12'h010 two cycles later, score_busy high one cycle.
- invader_collision=6'b100011 one cycle -> three consecutive serviced cycles; score 0->10->20->50; busy drops after the third.
- Score preset near 12'h990 via hits, then a 30-point hit -> score=12'h999, no wrap.
- Score reaches 12'h050 with lives=2 -> extra_life pulse, lives=3; a later crossing gives no second pulse.
- player_collision with lives=3 -> lives=2, player_alive low exactly RESPAWN_CYCLES cycles; a second player_collision in DYING leaves lives=2.
- Lives=1, player_collision -> game_over=1, lives=0; invader hit ignored; new_game -> score=0, lives=3, player_alive=1. With SCORE_KEEPER_HISCORE_EN, hiscore holds the final score.
